// File: rtl/stage4ma.sv
// stage4ma -- memory-access stage (stage 4) of the five-stage pipeline.
//
// Registers the instruction from execute and performs at most one load or
// store over a request/acknowledge data-memory port. It then hands pc,
// instruction, instruction set and result to stage 5. Non-memory instructions
// pass through with one cycle of latency. stall_out holds upstream while an
// access is outstanding.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   enable_in            valid instruction on the *_in inputs
//   pc_in, instr_in,
//   instr_set_in         pipeline fields from execute
//   mem_rd_in/mem_wr_in  load / store decode (both set => store)
//   addr_in, wdata_in    data-memory address and store data
//   alu_result_in        execute result for non-load instructions
//   dmem_*               request/acknowledge data-memory port
//   stall_out            stage busy (state == WAIT)
//   enable_out           one-cycle pulse when the *_out fields are new
//   pc_out, instr_out,
//   instr_set_out,
//   result_out           registered fields for stage 5
//   fault_out            with enable_out: the memory access was aborted
//
// Optional feature: define STAGE4MA_TIMEOUT_EN to abort a WAIT after
// TIMEOUT_CYCLES cycles without an ack (range 1..255).

module stage4ma #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_in,
  input  logic [11:0] pc_in,
  input  logic [11:0] instr_in,
  input  logic [3:0]  instr_set_in,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic [11:0] addr_in,
  input  logic [11:0] wdata_in,
  input  logic [11:0] alu_result_in,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [11:0] dmem_addr_out,
  output logic [11:0] dmem_wdata_out,
  input  logic        dmem_ack_in,
  input  logic [11:0] dmem_rdata_in,
  output logic        stall_out,
  output logic        enable_out,
  output logic [11:0] pc_out,
  output logic [11:0] instr_out,
  output logic [3:0]  instr_set_out,
  output logic [11:0] result_out,
  output logic        fault_out
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("stage4ma: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      state;

  // Fields of the in-flight memory instruction. They are kept apart from the
  // *_out registers so the outputs hold their last values until completion.
  logic [11:0] hold_pc;
  logic [11:0] hold_instr;
  logic [3:0]  hold_set;
  logic [11:0] hold_alu;
  logic        hold_load;

`ifdef STAGE4MA_TIMEOUT_EN
  // Abort fires on the edge that ends the TIMEOUT_CYCLES-th WAIT cycle.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]  wait_cnt;
  logic        fault_q;

  assign fault_out = fault_q;
`else
  assign fault_out = 1'b0;
`endif

  assign stall_out = (state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      dmem_req_out   <= 1'b0;
      dmem_we_out    <= 1'b0;
      dmem_addr_out  <= '0;
      dmem_wdata_out <= '0;
      enable_out     <= 1'b0;
      pc_out         <= '0;
      instr_out      <= '0;
      instr_set_out  <= '0;
      result_out     <= '0;
      hold_pc        <= '0;
      hold_instr     <= '0;
      hold_set       <= '0;
      hold_alu       <= '0;
      hold_load      <= 1'b0;
`ifdef STAGE4MA_TIMEOUT_EN
      wait_cnt       <= '0;
      fault_q        <= 1'b0;
`endif
    end else begin
      enable_out <= 1'b0;
`ifdef STAGE4MA_TIMEOUT_EN
      fault_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (enable_in) begin
            if (mem_rd_in || mem_wr_in) begin
              hold_pc        <= pc_in;
              hold_instr     <= instr_in;
              hold_set       <= instr_set_in;
              hold_alu       <= alu_result_in;
              hold_load      <= ~mem_wr_in;
              dmem_we_out    <= mem_wr_in;
              dmem_addr_out  <= addr_in;
              dmem_wdata_out <= wdata_in;
              dmem_req_out   <= 1'b1;
              state          <= WAIT;
`ifdef STAGE4MA_TIMEOUT_EN
              wait_cnt       <= '0;
`endif
            end else begin
              pc_out        <= pc_in;
              instr_out     <= instr_in;
              instr_set_out <= instr_set_in;
              result_out    <= alu_result_in;
              enable_out    <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (dmem_ack_in) begin
            dmem_req_out  <= 1'b0;
            pc_out        <= hold_pc;
            instr_out     <= hold_instr;
            instr_set_out <= hold_set;
            result_out    <= hold_load ? dmem_rdata_in : hold_alu;
            enable_out    <= 1'b1;
            state         <= IDLE;
          end
`ifdef STAGE4MA_TIMEOUT_EN
          else if (wait_cnt == WAIT_LIMIT) begin
            dmem_req_out  <= 1'b0;
            pc_out        <= hold_pc;
            instr_out     <= hold_instr;
            instr_set_out <= hold_set;
            result_out    <= '0;
            enable_out    <= 1'b1;
            fault_q       <= 1'b1;
            state         <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
